serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes a - b as a + ~b + 1, LSB first, using one full-adder cell and a carry flip-flop.
- Sequential counterpart of the parallel ripple negation/complement stage. It consumes the same WIDTH-bit operands and produces the difference plus carry/overflow flags for the downstream ALU result register.
- Trades WIDTH cycles of latency for a single adder cell.

Parameters:
- WIDTH, 5, operand and result width in bits (legal: 2..16).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request pulse; sampled only in IDLE or DONE.
- a, input, WIDTH, minuend; captured on accepted start.
- b, input, WIDTH, subtrahend; captured on accepted start.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when the result is valid.
- result, output, WIDTH, a - b mod 2^WIDTH; holds until the next completion.
- carry_out, output, 1, final adder carry (1 = no unsigned borrow, a >= b).
- overflow, output, 1, signed overflow (carry into MSB XOR carry out).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state = IDLE; busy, done, result, carry_out, overflow = 0; internal shift registers, counter and carry = 0.
- Reset mid-operation aborts the calculation. Nothing partial appears on the outputs.
- FSM states: IDLE, RUN, DONE.
- IDLE + start: load sh_a <= a, sh_b <= ~b, carry <= 1, cnt <= 0, then go to RUN. Without start, stay in IDLE.
- RUN, each cycle:
  - s = sh_a[0] ^ sh_b[0] ^ carry; carry <= majority(sh_a[0], sh_b[0], carry).
  - sh_a and sh_b shift right; sh_r shifts right with s inserted at the MSB.
  - cnt increments.
  - When cnt == WIDTH-2, the carry entering the MSB is stored in c_msb.
- RUN exit: on the cycle with cnt == WIDTH-1, go to DONE and, on that same edge, latch:
  - result <= {s, sh_r[WIDTH-1:1]};
  - carry_out <= new carry;
  - overflow <= c_msb ^ new carry.
- DONE: done = 1 for exactly one cycle.
  - start asserted in DONE: accepted back-to-back with IDLE load semantics, go to RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge t; busy is high after edges t+1..t+WIDTH; done is high after edge t+WIDTH+1 (one cycle).
- start while busy: ignored, no queueing. a and b may change freely after acceptance.
- result, carry_out and overflow change only on the completing edge or on reset. They are stable through IDLE and the next RUN.
- WIDTH == 2: the c_msb capture happens on the first RUN cycle (cnt == 0). Counter width is clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_SUB_ADD_MODE_EN.
- Defined: adds input port op_add (1 bit), sampled with start. op_add = 1 loads sh_b <= b and carry <= 0, so the block computes a + b; carry_out is the unsigned carry and overflow is the signed add overflow. op_add = 0 behaves as subtraction.
- Undefined: no op_add port; the block is subtract only.

Decomposition:
- Shared package serial_alu_pkg:
  - FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - default WIDTH constant.
- One sub-module, fa_cell: combinational full adder (s, cout from a, b, cin), instantiated once in the datapath.
- The FSM, counter and shift registers live in the top module.

Test Plan:
- WIDTH=5, reset held 2 cycles -> all outputs 0, busy=0. Then start with a=00000, b=10010 -> done exactly 6 cycles after start edge, result=01110, carry_out=0, overflow=0.
- a=00000, b=00000 -> result=00000, carry_out=1, overflow=0. Then a=00000, b=10000 -> result=10000, carry_out=0, overflow=1.
- a=01001, b=10101 -> result=10100, carry_out=0, overflow=1. Start re-asserted during RUN with a=11111 -> ignored; result unchanged from this operation.
- Back-to-back: start in DONE cycle with a=11111, b=00001 -> no IDLE cycle, second done 6 cycles later, result=11110, carry_out=1, overflow=0. First result held until then.
- Reset asserted on the 3rd RUN cycle -> next cycle IDLE, busy=0, done never pulses, result=0. A new start then completes normally.
- With SERIAL_SUB_ADD_MODE_EN: op_add=1, a=01001, b=01011 -> result=10100, carry_out=0, overflow=1. op_add=0 on the same operands -> result=11110, carry_out=0, overflow=0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU blocks.
//   state_e       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_alu_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder.
// Ports:
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out (majority of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: result = a - b computed as
// a + ~b + 1, LSB first, through one full-adder cell and a carry flop.
// Takes WIDTH RUN cycles per operation.
//
// Build option: define SERIAL_SUB_ADD_MODE_EN to add the op_add input
// (sampled with start); op_add = 1 computes a + b instead.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   start     : request pulse, accepted only in IDLE or DONE
//   a, b      : operands, captured on an accepted start
//   op_add    : (SERIAL_SUB_ADD_MODE_EN only) 1 = add, 0 = subtract
//   busy      : high while in RUN
//   done      : one-cycle pulse when result is valid
//   result    : difference mod 2^WIDTH, held until the next completion
//   carry_out : final adder carry (1 = no unsigned borrow)
//   overflow  : signed overflow (carry into MSB xor carry out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit per cycle through the adder cell, cnt = bit index
// DONE  | result valid, done pulses; start here reloads back-to-back
module serial_subtractor
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op_add,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  // Holds the upper WIDTH-1 sum bits; the final sum bit is taken straight
  // from the adder on the completing edge, so bit 0 of a full-width
  // register would never be read.
  logic [WIDTH-2:0] sh_r_q, sh_r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic fa_s, fa_cout;
  logic add_mode;

`ifdef SERIAL_SUB_ADD_MODE_EN
  assign add_mode = op_add;
`else
  assign add_mode = 1'b0;
`endif

  fa_cell u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    sh_r_d      = sh_r_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    c_msb_d     = c_msb_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract: a + ~b + 1. Add: a + b + 0.
          sh_a_d  = a;
          sh_b_d  = add_mode ? b : ~b;
          carry_d = ~add_mode;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        carry_d            = fa_cout;
        sh_a_d             = sh_a_q >> 1;
        sh_b_d             = sh_b_q >> 1;
        sh_r_d             = sh_r_q >> 1;
        sh_r_d[WIDTH-2]    = fa_s;
        cnt_d              = cnt_q + CW'(1);
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CW'(WIDTH - 2)) begin
          c_msb_d = fa_cout;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d    = {fa_s, sh_r_q};
          carry_out_d = fa_cout;
          overflow_d  = c_msb_q ^ fa_cout;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      sh_r_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      c_msb_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      sh_r_q      <= sh_r_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      c_msb_q     <= c_msb_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 5). Expected values
// come from plain integer arithmetic on the operands. Add-mode checks are
// included when SERIAL_SUB_ADD_MODE_EN is defined.
module tb_serial_subtractor;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_i, b_i;
  logic         busy, done;
  logic [W-1:0] result;
  logic         carry_out, overflow;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic         op_add_i;
`endif

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] prev_result;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a_i),
    .b         (b_i),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op_add    (op_add_i),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call #1 after a rising edge with the DUT in IDLE or DONE. Raises start,
  // then watches each following edge until done. If poke > 0, start is
  // re-raised with a = all ones during that RUN cycle (must be ignored).
  // Returns #1 after the edge on which done went high.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tadd, input int poke);
    int ua, ub, sa, sb, full, sres;
    logic [W-1:0] exp_r;
    logic exp_c, exp_v;
    int k;
    bit got;

    ua = int'(ta);
    ub = int'(tb);
    sa = ta[W-1] ? ua - (1 << W) : ua;
    sb = tb[W-1] ? ub - (1 << W) : ub;
    if (tadd) begin
      full  = ua + ub;
      sres  = sa + sb;
      exp_c = (full >= (1 << W));
    end else begin
      full  = ua - ub;
      sres  = sa - sb;
      exp_c = (ua >= ub);
    end
    exp_r = W'(full & ((1 << W) - 1));
    exp_v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));

    start = 1'b1;
    a_i   = ta;
    b_i   = tb;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op_add_i = tadd;
`endif
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      start = (k == poke);
      a_i   = (k == poke) ? '1 : W'($urandom);
      b_i   = W'($urandom);
`ifdef SERIAL_SUB_ADD_MODE_EN
      op_add_i = 1'($urandom);
`endif
      if (done) begin
        got = 1'b1;
      end else if (k <= W) begin
        check_eq("busy_run", 32'(busy), 32'd1);
        check_eq("result_hold", 32'(result), 32'(prev_result));
      end
    end
    start = 1'b0;
    check_eq("latency", 32'(k), 32'(W + 1));
    check_eq("result", 32'(result), 32'(exp_r));
    check_eq("carry_out", 32'(carry_out), 32'(exp_c));
    check_eq("overflow", 32'(overflow), 32'(exp_v));
    prev_result = exp_r;
  endtask

  task automatic idle_edge();
    @(posedge clk);
    #1;
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen_done;
    logic tadd;

    reset = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op_add_i = 1'b0;
`endif
    prev_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_carry", 32'(carry_out), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(5'b00000, 5'b10010, 1'b0, 0);
    idle_edge();
    run_op(5'b00000, 5'b00000, 1'b0, 0);
    idle_edge();
    // Start re-raised mid-run must be ignored and not queued.
    run_op(5'b00000, 5'b10000, 1'b0, 3);
    idle_edge();
    run_op(5'b01001, 5'b10101, 1'b0, 2);
    // Back-to-back: start accepted in the DONE cycle.
    run_op(5'b11111, 5'b00001, 1'b0, 0);
    idle_edge();

    // Reset during the third RUN cycle.
    start = 1'b1;
    a_i   = 5'b01010;
    b_i   = 5'b00011;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_result", 32'(result), 32'd0);
    check_eq("abort_carry", 32'(carry_out), 32'd0);
    check_eq("abort_ovf", 32'(overflow), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done;
    end
    check_eq("abort_no_done", 32'(seen_done), 32'd0);
    prev_result = '0;
    run_op(5'b01010, 5'b00011, 1'b0, 0);
    idle_edge();

`ifdef SERIAL_SUB_ADD_MODE_EN
    run_op(5'b01001, 5'b01011, 1'b1, 0);
    idle_edge();
    run_op(5'b01001, 5'b01011, 1'b0, 0);
    idle_edge();
`endif

    for (int i = 0; i < 60; i++) begin
`ifdef SERIAL_SUB_ADD_MODE_EN
      tadd = 1'($urandom);
`else
      tadd = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), tadd,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : 0);
      if ($urandom_range(0, 1) == 1) begin
        idle_edge();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
